// File: rtl/pic_pkg.sv
// Shared types and defaults for the PIC in-service register block.
// Holds the handshake state enum, EOI opcodes and the OCW2 decode helper.
package pic_pkg;

   localparam int NUM_IRQ_DEF = 8;
   localparam int VEC_W_DEF   = 8;

   typedef enum logic {
      IDLE,
      WAIT_SECOND
   } ackState_e;

   typedef enum logic [1:0] {
      EOI_NONE,
      EOI_NONSPEC,
      EOI_SPEC
   } eoiOp_e;

   function automatic eoiOp_e decodeEoi(input logic valid, input logic specific);
      eoiOp_e op;
      op = EOI_NONE;
      if (valid) begin
         op = specific ? EOI_SPEC : EOI_NONSPEC;
      end
      return op;
   endfunction

endpackage

// File: rtl/isr_priority_scan.sv
// Circular first-set finder: returns the first set bit of vector starting at
// base and walking upward modulo NUM_IRQ.
module isr_priority_scan #(
   parameter int  NUM_IRQ = 8,
   localparam int IDX_W   = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] vector,
   input  logic [IDX_W-1:0]   base,
   output logic [IDX_W-1:0]   index,
   output logic               found
);

   logic [IDX_W-1:0] pos;

   // Walk from the farthest offset back toward base so the nearest hit is written last.
   always_comb begin
      index = '0;
      found = 1'b0;
      pos   = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         pos = base + i[IDX_W-1:0];
         if (vector[pos]) begin
            index = pos;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/in_service_ctrl.sv
// In-service register with the two-pulse acknowledge handshake and EOI handling.
// Optional ISR_ROTATE_EN: an EOI with eoiRotate moves priorityBase past the cleared line.
module in_service_ctrl
   import pic_pkg::*;
#(
   parameter int  NUM_IRQ = NUM_IRQ_DEF,
   parameter int  VEC_W   = VEC_W_DEF,
   localparam int IDX_W   = $clog2(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               firstAck,
   input  logic [IDX_W-1:0]   setIndex,
   input  logic               secondAck,
   input  logic [VEC_W-1:0]   vectorBase,
   input  logic               autoEoi,
   input  logic               eoiValid,
   input  logic               eoiSpecific,
   input  logic [IDX_W-1:0]   eoiIndex,
   input  logic               eoiRotate,
   input  logic               setPrioValid,
   input  logic [IDX_W-1:0]   setPrioIndex,
   output logic [NUM_IRQ-1:0] isrValue,
   output logic [IDX_W-1:0]   priorityBase,
   output logic [VEC_W-1:0]   dataBuffer,
   output logic               dataValid,
   output logic [IDX_W-1:0]   resetedIndex,
   output logic               eoiDone
);

   ackState_e           state;
   logic [IDX_W-1:0]    capIdx;

   eoiOp_e              eoiOp;
   logic [IDX_W-1:0]    scanIdx;
   logic                scanFound;
   logic                eoiHit;
   logic [IDX_W-1:0]    eoiClrIdx;
   logic                aeoiHit;
   logic                setHit;
   logic [NUM_IRQ-1:0]  isrNext;
   logic [IDX_W-1:0]    vecIdx;
   logic                unusedBits;

   assign unusedBits = ^{vectorBase[IDX_W-1:0], eoiRotate};

   isr_priority_scan #(
      .NUM_IRQ(NUM_IRQ)
   ) uScan (
      .vector(isrValue),
      .base  (priorityBase),
      .index (scanIdx),
      .found (scanFound)
   );

   // Clears come first and the acknowledge set last, so a set to the same line wins.
   always_comb begin
      eoiOp     = decodeEoi(eoiValid, eoiSpecific);
      eoiHit    = 1'b0;
      eoiClrIdx = '0;
      case (eoiOp)
         EOI_SPEC: begin
            eoiHit    = 1'b1;
            eoiClrIdx = eoiIndex;
         end
         EOI_NONSPEC: begin
            eoiHit    = scanFound;
            eoiClrIdx = scanIdx;
         end
         default: begin
            eoiHit    = 1'b0;
            eoiClrIdx = '0;
         end
      endcase

      aeoiHit = secondAck && (state == WAIT_SECOND) && autoEoi;
      setHit  = firstAck && (state == IDLE);

      isrNext = isrValue;
      if (eoiHit) begin
         isrNext[eoiClrIdx] = 1'b0;
      end
      if (aeoiHit) begin
         isrNext[capIdx] = 1'b0;
      end
      if (setHit) begin
         isrNext[setIndex] = 1'b1;
      end

      vecIdx = (state == WAIT_SECOND) ? capIdx : '1;
   end

   // Handshake FSM plus every registered output of the block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         capIdx       <= '0;
         isrValue     <= '0;
         priorityBase <= '0;
         dataBuffer   <= '0;
         dataValid    <= 1'b0;
         resetedIndex <= '0;
         eoiDone      <= 1'b0;
      end else begin
         isrValue  <= isrNext;
         dataValid <= secondAck;
         eoiDone   <= eoiValid || aeoiHit;

         if (secondAck) begin
            dataBuffer <= {vectorBase[VEC_W-1:IDX_W], vecIdx};
         end

         // An OCW2 EOI owns resetedIndex even when an AEOI lands in the same cycle.
         if (eoiValid) begin
            if (eoiHit) begin
               resetedIndex <= eoiClrIdx;
            end
         end else if (aeoiHit) begin
            resetedIndex <= capIdx;
         end

         if (setPrioValid) begin
            priorityBase <= setPrioIndex;
         end
`ifdef ISR_ROTATE_EN
         else if (eoiValid && eoiRotate && eoiHit) begin
            priorityBase <= eoiClrIdx + IDX_W'(1);
         end
`endif

         case (state)
            IDLE: begin
               if (firstAck) begin
                  state  <= WAIT_SECOND;
                  capIdx <= setIndex;
               end
            end
            WAIT_SECOND: begin
               if (secondAck) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_in_service_ctrl.sv
// Self-checking bench for in_service_ctrl: directed vectors, literal checks and
// a per-cycle comparison against a modulo-arithmetic behavioural model.
module tb_in_service_ctrl;

   localparam int NIRQ = 8;
   localparam int VW   = 8;
   localparam int IW   = 3;
`ifdef ISR_ROTATE_EN
   localparam int ROT_EXP = 3;
`else
   localparam int ROT_EXP = 0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           firstAck;
   logic [IW-1:0]  setIndex;
   logic           secondAck;
   logic [VW-1:0]  vectorBase;
   logic           autoEoi;
   logic           eoiValid;
   logic           eoiSpecific;
   logic [IW-1:0]  eoiIndex;
   logic           eoiRotate;
   logic           setPrioValid;
   logic [IW-1:0]  setPrioIndex;
   logic [NIRQ-1:0] isrValue;
   logic [IW-1:0]  priorityBase;
   logic [VW-1:0]  dataBuffer;
   logic           dataValid;
   logic [IW-1:0]  resetedIndex;
   logic           eoiDone;

   int checks = 0;
   int failures = 0;

   in_service_ctrl #(
      .NUM_IRQ(NIRQ),
      .VEC_W  (VW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .firstAck    (firstAck),
      .setIndex    (setIndex),
      .secondAck   (secondAck),
      .vectorBase  (vectorBase),
      .autoEoi     (autoEoi),
      .eoiValid    (eoiValid),
      .eoiSpecific (eoiSpecific),
      .eoiIndex    (eoiIndex),
      .eoiRotate   (eoiRotate),
      .setPrioValid(setPrioValid),
      .setPrioIndex(setPrioIndex),
      .isrValue    (isrValue),
      .priorityBase(priorityBase),
      .dataBuffer  (dataBuffer),
      .dataValid   (dataValid),
      .resetedIndex(resetedIndex),
      .eoiDone     (eoiDone)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   bit [NIRQ-1:0] mIsr;
   bit [NIRQ-1:0] newIsr;
   int  mBase, mData, mValid, mResIdx, mDone, mCap, clrIdx;
   bit  mWaiting, aeoi, modelLive = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model follows the rules directly: modulo scan for non-specific EOI, then set.
   always @(posedge clk) begin
      modelLive = 1;
      if (rst) begin
         mIsr = 0; mBase = 0; mData = 0; mValid = 0; mResIdx = 0; mDone = 0;
         mWaiting = 0; mCap = 0;
      end else begin
         clrIdx = -1;
         if (eoiValid) begin
            if (eoiSpecific) clrIdx = int'(eoiIndex);
            else
               for (int k = 0; k < NIRQ; k++)
                  if (clrIdx < 0 && mIsr[(mBase + k) % NIRQ]) clrIdx = (mBase + k) % NIRQ;
         end
         aeoi = secondAck && mWaiting && autoEoi;
         newIsr = mIsr;
         if (clrIdx >= 0) newIsr[clrIdx] = 0;
         if (aeoi) newIsr[mCap] = 0;
         if (firstAck && !mWaiting) newIsr[setIndex] = 1;
         mDone = (eoiValid || aeoi) ? 1 : 0;
         if (eoiValid) begin
            if (clrIdx >= 0) mResIdx = clrIdx;
         end else if (aeoi) mResIdx = mCap;
         mValid = secondAck ? 1 : 0;
         if (secondAck) mData = (int'(vectorBase) & 'hF8) + (mWaiting ? mCap : NIRQ - 1);
`ifdef ISR_ROTATE_EN
         if (eoiValid && eoiRotate && clrIdx >= 0) mBase = (clrIdx + 1) % NIRQ;
`endif
         if (setPrioValid) mBase = int'(setPrioIndex);
         if (firstAck && !mWaiting) begin
            mWaiting = 1;
            mCap = int'(setIndex);
         end else if (secondAck && mWaiting) begin
            mWaiting = 0;
         end
         mIsr = newIsr;
      end
   end

   always @(negedge clk) begin
      if (modelLive) begin
         checkOutput("model isrValue", isrValue, mIsr);
         checkOutput("model priorityBase", priorityBase, mBase);
         checkOutput("model dataBuffer", dataBuffer, mData);
         checkOutput("model dataValid", dataValid, mValid);
         checkOutput("model resetedIndex", resetedIndex, mResIdx);
         checkOutput("model eoiDone", eoiDone, mDone);
      end
   end

   // One clock with the current inputs, then pulses are dropped.
   task automatic applyStimulus();
      @(posedge clk);
      @(negedge clk);
      #1;
      firstAck = 0; secondAck = 0; eoiValid = 0; setPrioValid = 0;
   endtask

   task automatic ackPair(input int idx);
      firstAck = 1; setIndex = IW'(idx);
      applyStimulus();
      secondAck = 1;
      applyStimulus();
   endtask

   task automatic doEoi(input bit spec, input int idx, input bit rot);
      eoiValid = 1; eoiSpecific = spec; eoiIndex = IW'(idx); eoiRotate = rot;
      applyStimulus();
      eoiRotate = 0;
   endtask

   initial begin
      rst = 1; firstAck = 0; setIndex = 0; secondAck = 0; vectorBase = 8'h40;
      autoEoi = 0; eoiValid = 0; eoiSpecific = 0; eoiIndex = 0; eoiRotate = 0;
      setPrioValid = 0; setPrioIndex = 0;
      applyStimulus();
      applyStimulus();
      rst = 0;
      checkOutput("reset isrValue", isrValue, 0);
      checkOutput("reset dataValid", dataValid, 0);
      checkOutput("reset dataBuffer", dataBuffer, 0);

      // 1: basic handshake
      firstAck = 1; setIndex = 3;
      applyStimulus();
      checkOutput("t1 isr after firstAck", isrValue, 8'h08);
      secondAck = 1;
      applyStimulus();
      checkOutput("t1 dataBuffer", dataBuffer, 8'h43);
      checkOutput("t1 dataValid", dataValid, 1);
      applyStimulus();
      checkOutput("t1 dataValid drop", dataValid, 0);

      // 2: non-specific EOI from two bases
      ackPair(5);
      checkOutput("t2 isr setup", isrValue, 8'h28);
      doEoi(0, 0, 0);
      checkOutput("t2 isr base0", isrValue, 8'h20);
      checkOutput("t2 resetedIndex base0", resetedIndex, 3);
      checkOutput("t2 eoiDone", eoiDone, 1);
      ackPair(3);
      setPrioValid = 1; setPrioIndex = 4;
      applyStimulus();
      doEoi(0, 0, 0);
      checkOutput("t2 isr base4", isrValue, 8'h08);
      checkOutput("t2 resetedIndex base4", resetedIndex, 5);
      setPrioValid = 1; setPrioIndex = 0;
      applyStimulus();
      doEoi(1, 3, 0);
      checkOutput("t2 isr cleared", isrValue, 8'h00);

      // 3: automatic EOI
      autoEoi = 1;
      firstAck = 1; setIndex = 6;
      applyStimulus();
      checkOutput("t3 isr set", isrValue, 8'h40);
      secondAck = 1;
      applyStimulus();
      checkOutput("t3 dataBuffer", dataBuffer, 8'h46);
      checkOutput("t3 isr", isrValue, 8'h00);
      checkOutput("t3 eoiDone", eoiDone, 1);
      checkOutput("t3 resetedIndex", resetedIndex, 6);
      autoEoi = 0;

      // 4: spurious second ack and EOI on empty ISR
      ackPair(1);
      secondAck = 1;
      applyStimulus();
      checkOutput("t4 spurious vector", dataBuffer, 8'h47);
      checkOutput("t4 isr unchanged", isrValue, 8'h02);
      doEoi(1, 1, 0);
      doEoi(0, 0, 0);
      checkOutput("t4 empty eoiDone", eoiDone, 1);
      checkOutput("t4 empty resetedIndex", resetedIndex, 1);
      checkOutput("t4 empty isr", isrValue, 8'h00);

      // 5: rotation on EOI
      ackPair(2);
      doEoi(0, 0, 1);
      checkOutput("t5 priorityBase", priorityBase, ROT_EXP);
      setPrioValid = 1; setPrioIndex = 0;
      applyStimulus();

      // Same-cycle set and specific EOI on one line: set wins
      ackPair(2);
      firstAck = 1; setIndex = 2; eoiValid = 1; eoiSpecific = 1; eoiIndex = 2;
      applyStimulus();
      checkOutput("same-line set wins", isrValue, 8'h04);
      secondAck = 1;
      applyStimulus();
      doEoi(1, 2, 0);

      // 6: reset mid-handshake
      firstAck = 1; setIndex = 5;
      applyStimulus();
      rst = 1;
      applyStimulus();
      rst = 0;
      checkOutput("t6 isr after rst", isrValue, 8'h00);
      checkOutput("t6 resetedIndex after rst", resetedIndex, 0);
      secondAck = 1;
      applyStimulus();
      checkOutput("t6 spurious after rst", dataBuffer, 8'h47);
      checkOutput("t6 isr", isrValue, 8'h00);
      applyStimulus();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
